// File: rtl/vx_alu_dot8_seq.sv
// Sequential int8 dot-product PE: one warp request in, per-lane 4-term signed
// byte dot product accumulated over four cycles, result held on the commit channel.
module vx_alu_dot8_seq #(
    parameter int NUM_LANES = 4,
    parameter int XLEN      = 32,
    parameter int HDR_W     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      execute_valid,
    output logic                      execute_ready,
    input  logic [HDR_W-1:0]          execute_header,
    input  logic [NUM_LANES*XLEN-1:0] execute_rs1,
    input  logic [NUM_LANES*XLEN-1:0] execute_rs2,
    output logic                      commit_valid,
    input  logic                      commit_ready,
    output logic [HDR_W-1:0]          commit_header,
    output logic [NUM_LANES*XLEN-1:0] commit_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [1:0]                cnt_r;
    logic [HDR_W-1:0]          hdr_r;
    logic [NUM_LANES*XLEN-1:0] rs1_r;
    logic [NUM_LANES*XLEN-1:0] rs2_r;
    logic signed [17:0]        acc_r [NUM_LANES];
    logic                      exe_fire_s;
    logic                      com_fire_s;

    // Signed 8x8 product widened to the 18-bit accumulator width.
    function automatic logic signed [17:0] byte_prod(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return {{2{p[15]}}, p};
    endfunction

    assign exe_fire_s = execute_valid && execute_ready;
    assign com_fire_s = commit_valid && commit_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (exe_fire_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 2'd3) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (com_fire_s) begin
                    if (exe_fire_s) begin
                        state_nxt_s = CALC;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; reset gates ready so nothing is accepted while held in reset.
    always_comb begin
        execute_ready = 1'b0;
        commit_valid  = 1'b0;
        case (state_r)
            IDLE: begin
                execute_ready = ~reset;
                commit_valid  = 1'b0;
            end
            CALC: begin
                execute_ready = 1'b0;
                commit_valid  = 1'b0;
            end
            DONE: begin
                execute_ready = ~reset & commit_ready;
                commit_valid  = 1'b1;
            end
            default: begin
                execute_ready = 1'b0;
                commit_valid  = 1'b0;
            end
        endcase
    end

    // Result drive: headers and sign-extended accumulators straight from registers.
    always_comb begin
        commit_header = hdr_r;
        commit_data   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            commit_data[i*XLEN +: XLEN] = {{(XLEN-18){acc_r[i][17]}}, acc_r[i]};
        end
    end

    // Operand capture and per-lane byte accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 2'd0;
            hdr_r <= '0;
            rs1_r <= '0;
            rs2_r <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc_r[i] <= 18'sd0;
            end
        end else if (exe_fire_s) begin
            cnt_r <= 2'd0;
            hdr_r <= execute_header;
            rs1_r <= execute_rs1;
            rs2_r <= execute_rs2;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc_r[i] <= 18'sd0;
            end
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r + 2'd1;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc_r[i] <= acc_r[i] + byte_prod(rs1_r[i*XLEN + {cnt_r, 3'b000} +: 8],
                                                 rs2_r[i*XLEN + {cnt_r, 3'b000} +: 8]);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule
